// File: rtl/sort_pkg.sv
// sort_pkg: shared types, init modes and compare helper for the sort RAM
package sort_pkg;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_SWAP, OP_CMPSWAP} op_e;
  typedef enum logic [1:0] {S_INIT, S_IDLE, S_XCHG} state_e;
  localparam int INIT_ZERO = 0;
  localparam int INIT_DESC = 1;
  localparam int INIT_NONE = 2;
  // Flipping the sign bit maps two's complement onto offset binary, so one unsigned compare serves both
  function automatic logic cmp_gt(input logic [63:0] a, input logic [63:0] b, input int w, input logic sgn);
    logic [63:0] flip;
    flip = sgn ? (64'd1 << (w - 1)) : 64'd0;
    return (a ^ flip) > (b ^ flip);
  endfunction
endpackage

// File: rtl/sort_ram_core.sv
// sort_ram_core: storage array with two async read ports and two write ports
module sort_ram_core #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data
);
  logic [DATA_W-1:0] mem [DEPTH];
  assign ra_data = 32'(ra_addr) < DEPTH ? mem[ra_addr] : '0;
  assign rb_data = 32'(rb_addr) < DEPTH ? mem[rb_addr] : '0;
  always_ff @(posedge clk) begin
    if (wa_en && 32'(wa_addr) < DEPTH) mem[wa_addr] <= wa_data;
    if (wb_en && 32'(wb_addr) < DEPTH) mem[wb_addr] <= wb_data;
  end
endmodule

// File: rtl/sort_ram.sv
// sort_ram: request-port data store with init fill, dual reads and atomic SWAP/CMPSWAP
module sort_ram
  import sort_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int INIT_MODE  = 1,
  parameter int SIGNED_CMP = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr_a,
  input  logic [ADDR_W-1:0] req_addr_b,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata_a,
  output logic [DATA_W-1:0] rsp_rdata_b,
  output logic              rsp_swapped,
  output logic              init_done
);
  state_e state;
  op_e op;
  logic [ADDR_W-1:0] cnt, xa, xb, wa_addr;
  logic [DATA_W-1:0] xda, xdb, rd_a, rd_b, wa_data, pattern;
  logic xch, xch_next, acc, wa_en, wb_en;
  always_comb begin
    op = op_e'(req_op);
    acc = req_valid && req_ready;
    pattern = INIT_MODE == INIT_ZERO ? '0 : DATA_W'(DEPTH - 1 - 32'(cnt));
    xch_next = req_addr_a != req_addr_b && 32'(req_addr_a) < DEPTH && 32'(req_addr_b) < DEPTH &&
               (op == OP_SWAP || cmp_gt(64'(rd_a), 64'(rd_b), DATA_W, SIGNED_CMP != 0));
    // Gating with rst keeps the array untouched while reset is held
    wa_en = !rst && (state == S_INIT ? INIT_MODE != INIT_NONE : state == S_XCHG ? xch : acc && op == OP_WRITE);
    wa_addr = state == S_INIT ? cnt : state == S_XCHG ? xa : req_addr_a;
    wa_data = state == S_INIT ? pattern : state == S_XCHG ? xdb : req_wdata;
    wb_en = !rst && state == S_XCHG && xch;
  end
  sort_ram_core #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_core (
    .clk(clk), .ra_addr(req_addr_a), .rb_addr(req_addr_b), .ra_data(rd_a), .rb_data(rd_b),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(xb), .wb_data(xda)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_INIT;
      cnt <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata_a <= '0;
      rsp_rdata_b <= '0;
      rsp_swapped <= 1'b0;
      init_done <= 1'b0;
      xa <= '0;
      xb <= '0;
      xda <= '0;
      xdb <= '0;
      xch <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_INIT: begin
          cnt <= cnt + ADDR_W'(1);
          if (INIT_MODE == INIT_NONE || cnt == ADDR_W'(DEPTH - 1)) begin
            state <= S_IDLE;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end
        end
        S_IDLE: if (acc) begin
          if (op == OP_SWAP || op == OP_CMPSWAP) begin
            state <= S_XCHG;
            req_ready <= 1'b0;
            xa <= req_addr_a;
            xb <= req_addr_b;
            xda <= rd_a;
            xdb <= rd_b;
            xch <= xch_next;
          end else begin
            rsp_valid <= 1'b1;
            rsp_rdata_a <= rd_a;
            rsp_rdata_b <= rd_b;
            rsp_swapped <= 1'b0;
          end
        end
        S_XCHG: begin
          state <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b1;
          rsp_rdata_a <= xda;
          rsp_rdata_b <= xdb;
          rsp_swapped <= xch;
        end
        default: state <= S_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_sort_ram.sv
// tb_sort_ram: directed checks of init fill, pipelined access, exchanges and reset abort
module tb_sort_ram;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0;
  logic [1:0] req_op = '0;
  logic [2:0] a = '0, b = '0;
  logic [7:0] wd = '0;
  logic rdy1, v1, sw1, done1, rdy2, v2, sw2, done2;
  logic [7:0] ra1, rb1, ra2, rb2;
  int checks = 0, failures = 0, n;
  always #5 clk = ~clk;
  sort_ram u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req_op(req_op),
    .req_addr_a(a), .req_addr_b(b), .req_wdata(wd), .rsp_valid(v1),
    .rsp_rdata_a(ra1), .rsp_rdata_b(rb1), .rsp_swapped(sw1), .init_done(done1)
  );
  // Second instance: signed compare, no fill, so its contents survive a reset
  sort_ram #(.INIT_MODE(2), .SIGNED_CMP(1)) u2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy2), .req_op(req_op),
    .req_addr_a(a), .req_addr_b(b), .req_wdata(wd), .rsp_valid(v2),
    .rsp_rdata_a(ra2), .rsp_rdata_b(rb2), .rsp_swapped(sw2), .init_done(done2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [1:0] op, input logic [2:0] aa, input logic [2:0] bb, input logic [7:0] d);
    req_valid = 1'b1;
    req_op = op;
    a = aa;
    b = bb;
    wd = d;
  endtask
  task automatic idle;
    req_valid = 1'b0;
  endtask
  task automatic wait_init(input string tag);
    n = 0;
    while (!done1 && n < 20) begin
      tick;
      n++;
    end
    chk(tag, n, 8);
  endtask
  initial begin
    tick;
    tick;
    chk("rst_ready", rdy1, 0);
    chk("rst_valid", v1, 0);
    chk("rst_rdata_a", ra1, 0);
    chk("rst_rdata_b", rb1, 0);
    chk("rst_swapped", sw1, 0);
    chk("rst_init_done", done1, 0);
    chk("rst_init_done2", done2, 0);
    @(negedge clk) rst = 1'b0;
    wait_init("init_cycles");
    chk("init_ready", rdy1, 1);
    chk("nofill_done", done2, 1);
    drive(0, 0, 7, 0);
    chk("pre_valid", v1, 0);
    tick;
    idle;
    chk("rd_valid", v1, 1);
    chk("rd_a", ra1, 7);
    chk("rd_b", rb1, 0);
    chk("rd_swapped", sw1, 0);
    tick;
    chk("rd_pulse", v1, 0);
    chk("rd_hold", ra1, 7);
    drive(1, 3, 0, 8'hA5);
    tick;
    drive(0, 3, 3, 0);
    chk("wr_valid", v1, 1);
    chk("wr_old_a", ra1, 4);
    chk("wr_b", rb1, 7);
    chk("wr_ready", rdy1, 1);
    tick;
    idle;
    chk("b2b_valid", v1, 1);
    chk("b2b_a", ra1, 8'hA5);
    chk("b2b_b", rb1, 8'hA5);
    chk("b2b_ready", rdy1, 1);
    drive(3, 0, 7, 0);
    tick;
    idle;
    chk("cs_busy", rdy1, 0);
    chk("cs_novalid", v1, 0);
    tick;
    chk("cs_valid", v1, 1);
    chk("cs_swapped", sw1, 1);
    chk("cs_a", ra1, 7);
    chk("cs_b", rb1, 0);
    chk("cs_ready", rdy1, 1);
    drive(0, 0, 7, 0);
    tick;
    idle;
    chk("cs_mem0", ra1, 0);
    chk("cs_mem7", rb1, 7);
    drive(3, 0, 7, 0);
    tick;
    idle;
    tick;
    chk("cs2_valid", v1, 1);
    chk("cs2_swapped", sw1, 0);
    drive(0, 0, 7, 0);
    tick;
    idle;
    chk("cs2_mem0", ra1, 0);
    chk("cs2_mem7", rb1, 7);
    drive(1, 1, 0, 8'h80);
    tick;
    drive(1, 2, 0, 8'h01);
    tick;
    drive(3, 1, 2, 0);
    tick;
    idle;
    tick;
    chk("unsigned_swapped", sw1, 1);
    chk("signed_valid", v2, 1);
    chk("signed_swapped", sw2, 0);
    chk("signed_a", ra2, 8'h80);
    chk("signed_b", rb2, 8'h01);
    drive(2, 5, 5, 0);
    tick;
    idle;
    tick;
    chk("swap_same_swapped", sw1, 0);
    chk("swap_same_a", ra1, 2);
    drive(0, 5, 5, 0);
    tick;
    idle;
    chk("swap_same_mem", ra1, 2);
    drive(2, 2, 6, 0);
    tick;
    idle;
    tick;
    chk("swap_swapped", sw1, 1);
    chk("swap_a", ra1, 8'h80);
    chk("swap_b", rb1, 8'h01);
    drive(0, 2, 6, 0);
    tick;
    idle;
    chk("swap_mem2", ra1, 8'h01);
    chk("swap_mem6", rb1, 8'h80);
    drive(2, 1, 3, 0);
    tick;
    idle;
    rst = 1'b1;
    #2;
    chk("abort_valid", v1, 0);
    chk("abort_ready", rdy1, 0);
    chk("abort_done", done1, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_norsp", v1, 0);
    chk("abort_norsp2", v2, 0);
    @(negedge clk) rst = 1'b0;
    wait_init("reinit_cycles");
    drive(0, 1, 3, 0);
    tick;
    idle;
    chk("reinit_mem1", ra1, 6);
    chk("reinit_mem3", rb1, 4);
    chk("abort_kept1", ra2, 8'h80);
    chk("abort_kept3", rb2, 8'hA5);
    drive(0, 0, 7, 0);
    tick;
    idle;
    chk("reinit_mem0", ra1, 7);
    chk("reinit_mem7", rb1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sort_ram.md
Name: sort_ram

Overview:
- Parametrised single-clock data store for the sort system; successor to the fixed 8x8 RAM.
- Adds configurable width and depth, a post-reset initialisation engine, and a valid/ready request port.
- Provides dual-address reads plus atomic SWAP and compare-and-swap (CMPSWAP) operations, so the sort controller can exchange elements without read/write sequencing.
- Sits between the sort controller and the storage array.

Parameters:
- DATA_W, 8, element width in bits.
- DEPTH, 8, number of elements; any value >= 2.
- ADDR_W, $clog2(DEPTH), address width; derived, do not override.
- INIT_MODE, 1, post-reset fill: 0 = all zero, 1 = descending (mem[i] = DEPTH-1-i, truncated to DATA_W), 2 = no fill (contents undefined until written).
- SIGNED_CMP, 0, CMPSWAP compare: 0 = unsigned, 1 = two's-complement signed.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a clk edge.
- req_op  in  2  operation: 0 READ, 1 WRITE, 2 SWAP, 3 CMPSWAP.
- req_addr_a  in  ADDR_W  first address.
- req_addr_b  in  ADDR_W  second address; used by READ, SWAP and CMPSWAP.
- req_wdata  in  DATA_W  write data; WRITE only.
- rsp_valid  out  1  one-cycle pulse, one per accepted request.
- rsp_rdata_a  out  DATA_W  pre-operation mem[addr_a].
- rsp_rdata_b  out  DATA_W  pre-operation mem[addr_b].
- rsp_swapped  out  1  set when an exchange was written.
- init_done  out  1  high once the init engine has finished.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata_a=0, rsp_rdata_b=0, rsp_swapped=0, init_done=0. FSM goes to S_INIT; init counter = 0.
- The memory array is not reset; only the init engine modifies it.
- S_INIT:
  - Each cycle writes mem[cnt] = pattern, then cnt++.
  - After writing DEPTH-1, go to S_IDLE and set init_done=1. Fill takes exactly DEPTH cycles.
  - INIT_MODE=2 goes to S_IDLE on the first edge after reset release.
  - req_ready=0 throughout.
- S_IDLE: req_ready=1.
  - READ accepted at edge T: rsp_valid=1 in cycle T+1 with rdata_a/b = mem[a]/mem[b]; rsp_swapped=0.
  - WRITE accepted at edge T: mem[a] <= req_wdata at edge T. Response in cycle T+1 with rdata_a = old mem[a] and rdata_b = mem[b] sampled before the write.
  - READ and WRITE are fully pipelined, one per cycle.
  - SWAP/CMPSWAP accepted at edge T: latch a, b, mem[a], mem[b] and the exchange decision, then go to S_XCHG.
- Exchange decision:
  - SWAP: exchange = (a != b).
  - CMPSWAP: exchange = (a != b) && (mem[a] > mem[b]), using the comparison selected by SIGNED_CMP. Equal values do not swap.
- S_XCHG (one cycle, req_ready=0):
  - If exchange, write both words at edge T+1: mem[a] <= old b, mem[b] <= old a.
  - Return to S_IDLE.
  - rsp_valid=1 in cycle T+2 with pre-op data and rsp_swapped = exchange.
  - Next request can be accepted at edge T+2.
- Response outputs hold their last values while rsp_valid=0.
- Out-of-range addresses (>= DEPTH, non-power-of-two depth): reads return 0, writes are dropped, SWAP/CMPSWAP never exchange.
- Reset asserted mid-operation: any pending S_XCHG writeback is abandoned and no response is issued. The init engine restarts from 0 after release.

Decomposition:
- Package sort_pkg: op enum (OP_READ, OP_WRITE, OP_SWAP, OP_CMPSWAP), FSM state enum (S_INIT, S_IDLE, S_XCHG), INIT_MODE constants, and a compare function parameterised by signedness.
- The storage array is a natural sub-module, sort_ram_core (two async read ports, two write ports, parametrised DATA_W/DEPTH).
- FSM, init engine and response logic stay in sort_ram.

Test Plan:
- Init fill (defaults): release rst; count edges -> init_done rises after exactly 8 cycles; READ a=0, b=7 -> rdata_a=7, rdata_b=0, rsp_valid 1 cycle after acceptance.
- Back-to-back: WRITE a=3 data=0xA5, then READ a=3 b=3 on the next cycle -> WRITE rsp rdata_a=4; READ rsp rdata_a=rdata_b=0xA5; req_ready stays 1.
- CMPSWAP a=0 (7), b=7 (0) -> req_ready low 1 cycle; rsp at T+2 with swapped=1; follow-up READ gives mem[0]=0, mem[7]=7. Repeat the same CMPSWAP -> swapped=0, contents unchanged.
- SIGNED_CMP=1: write mem[1]=0x80, mem[2]=0x01; CMPSWAP a=1 b=2 -> swapped=0. Same with SIGNED_CMP=0 -> swapped=1.
- SWAP a=b=5 -> swapped=0, mem[5] unchanged; SWAP a=2 b=6 -> values exchanged.
- Assert rst during S_XCHG -> no rsp_valid, no exchange written; init restarts and mem returns to 7..0 after 8 cycles.
